// File: rtl/lif_pkg.sv
// lif_pkg: shared constants, saturation helper and FSM state type for the
// leaky integrate-and-fire population.
//   LIF_N_NEURONS / LIF_IDX_W / LIF_REFRAC_W : default sizing of the population
//   V_W                                     : membrane potential width (signed)
//   V_MAX / V_MIN                           : saturation limits
//   sat_add                                 : V_W+1 signed -> V_W signed clamp
package lif_pkg;

  localparam int LIF_N_NEURONS = 128;
  localparam int LIF_IDX_W     = 7;
  localparam int LIF_REFRAC_W  = 4;
  localparam int V_W           = 32;

  localparam logic signed [V_W-1:0] V_MAX = {1'b0, {(V_W-1){1'b1}}};
  localparam logic signed [V_W-1:0] V_MIN = {1'b1, {(V_W-1){1'b0}}};

  typedef enum logic {
    ACCEPT = 1'b0,
    UPDATE = 1'b1
  } lif_state_e;

  // The two top bits disagree exactly when the wide result is outside the
  // V_W-bit range; the top bit then tells which rail to clamp to.
  function automatic logic signed [V_W-1:0] sat_add(input logic signed [V_W:0] x);
    if (x[V_W] != x[V_W-1]) return x[V_W] ? V_MIN : V_MAX;
    return x[V_W-1:0];
  endfunction

endpackage

// File: rtl/lif_state_ram.sv
// lif_state_ram: simple dual-port RAM, one registered read port and one write
// port, no reset (contents are undefined until written).
//   clk        : clock
//   rd_en_i    : read strobe, rd_data_o updates on the next edge
//   rd_addr_i  : read address
//   rd_data_o  : registered read data
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
module lif_state_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 36
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lif_population.sv
// lif_population: time-multiplexed leaky integrate-and-fire population.
// One neuron is updated per accepted current sample; the neuron index runs
// 0..N_NEURONS-1 and wraps. Membrane potential and refractory count live in
// lif_state_ram.
//   clk, reset            : clock, asynchronous active-high reset
//   i_in/i_valid/i_ready  : synaptic current for the current index
//   v_thresh/v_reset      : firing threshold, post-spike/initial potential
//   leak_shift            : leak = v >>> leak_shift, 0 disables leak
//   refrac_len            : refractory updates after a spike
//   spike_out/spike_idx/v_out/out_valid : per-neuron result
//   pass_done             : pulse with the result for index N_NEURONS-1
//   pop_spike_count       : spikes in the last completed pass
//   hist_out              : 32-bit spike history (only with LIF_SPIKE_HIST_EN)
// Optional feature macro: LIF_SPIKE_HIST_EN.
module lif_population
  import lif_pkg::*;
#(
  parameter int N_NEURONS = LIF_N_NEURONS,
  parameter int IDX_W     = LIF_IDX_W,
  parameter int REFRAC_W  = LIF_REFRAC_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [V_W-1:0] i_in,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic signed [V_W-1:0] v_thresh,
  input  logic signed [V_W-1:0] v_reset,
  input  logic [3:0]            leak_shift,
  input  logic [REFRAC_W-1:0]   refrac_len,
  output logic                  spike_out,
  output logic [IDX_W-1:0]      spike_idx,
  output logic                  out_valid,
  output logic signed [V_W-1:0] v_out,
  output logic                  pass_done,
`ifdef LIF_SPIKE_HIST_EN
  output logic [31:0]           hist_out,
`endif
  output logic [IDX_W:0]        pop_spike_count
);

  lif_state_e state_q, state_d;

  logic [IDX_W-1:0]      idx_q;
  logic                  first_pass_q;
  logic [IDX_W:0]        cnt_q;
  logic signed [V_W-1:0] i_lat_q;

  logic                  spike_q, out_valid_q, pass_done_q;
  logic [IDX_W-1:0]      spike_idx_q;
  logic signed [V_W-1:0] v_out_q;
  logic [IDX_W:0]        pop_q;

  logic                         rd_en, wr_en;
  logic [V_W+REFRAC_W-1:0]      rd_data;
  logic signed [V_W-1:0]        rd_v, v_cur, leak_sh, leak, v_next, v_store, v_o;
  logic [REFRAC_W-1:0]          rd_r, r_cur, r_new;
  logic signed [V_W:0]          sum;
  logic                         spike;
  logic                         last_idx;

  assign rd_v = rd_data[V_W-1:0];
  assign rd_r = rd_data[V_W+REFRAC_W-1:V_W];

  always_comb begin
    state_d = state_q;
    i_ready = (state_q == ACCEPT);
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ACCEPT: if (i_valid) begin
        rd_en   = 1'b1;
        state_d = UPDATE;
      end
      UPDATE: begin
        wr_en   = 1'b1;
        state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end

  // RAM contents are meaningless until the first pass has written them.
  assign v_cur   = first_pass_q ? v_reset : rd_v;
  assign r_cur   = first_pass_q ? '0 : rd_r;
  assign leak_sh = v_cur >>> leak_shift;
  assign leak    = (leak_shift != 4'd0) ? leak_sh : '0;
  // v - leak always fits in V_W bits; adding i_in needs one extra bit.
  assign sum     = {v_cur[V_W-1], v_cur} - {leak[V_W-1], leak} + {i_lat_q[V_W-1], i_lat_q};
  assign v_next  = sat_add(sum);

  always_comb begin
    spike   = 1'b0;
    v_store = v_next;
    v_o     = v_next;
    r_new   = r_cur;
    if (r_cur != '0) begin
      v_store = v_reset;
      v_o     = v_reset;
      r_new   = r_cur - 1'b1;
    end else if (v_next >= v_thresh) begin
      spike   = 1'b1;
      v_store = v_reset;
      r_new   = refrac_len;
    end
  end

  assign last_idx = (idx_q == IDX_W'(N_NEURONS - 1));

  lif_state_ram #(.DEPTH(N_NEURONS), .AW(IDX_W), .DW(V_W + REFRAC_W)) u_state_ram (
    .clk       (clk),
    .rd_en_i   (rd_en),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q),
    .wr_data_i ({r_new, v_store})
  );

`ifdef LIF_SPIKE_HIST_EN
  logic [31:0] hist_rd, hist_new, hist_q;

  assign hist_new = first_pass_q ? {31'd0, spike} : {hist_rd[30:0], spike};

  lif_state_ram #(.DEPTH(N_NEURONS), .AW(IDX_W), .DW(32)) u_hist_ram (
    .clk       (clk),
    .rd_en_i   (rd_en),
    .rd_addr_i (idx_q),
    .rd_data_o (hist_rd),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q),
    .wr_data_i (hist_new)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= '0;
    else if (state_q == UPDATE) hist_q <= hist_new;
  end

  assign hist_out = hist_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ACCEPT;
      idx_q        <= '0;
      first_pass_q <= 1'b1;
      cnt_q        <= '0;
      i_lat_q      <= '0;
      spike_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      pass_done_q  <= 1'b0;
      spike_idx_q  <= '0;
      v_out_q      <= '0;
      pop_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      pass_done_q <= 1'b0;
      if (state_q == ACCEPT && i_valid) i_lat_q <= i_in;
      if (state_q == UPDATE) begin
        out_valid_q <= 1'b1;
        spike_q     <= spike;
        spike_idx_q <= idx_q;
        v_out_q     <= v_o;
        if (last_idx) begin
          idx_q        <= '0;
          pass_done_q  <= 1'b1;
          pop_q        <= cnt_q + {{IDX_W{1'b0}}, spike};
          cnt_q        <= '0;
          first_pass_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
          cnt_q <= cnt_q + {{IDX_W{1'b0}}, spike};
        end
      end
    end
  end

  assign spike_out       = spike_q;
  assign spike_idx       = spike_idx_q;
  assign out_valid       = out_valid_q;
  assign v_out           = v_out_q;
  assign pass_done       = pass_done_q;
  assign pop_spike_count = pop_q;

endmodule

// File: tb/tb_lif_population.sv
module tb_lif_population;

  localparam int N = 128;
  localparam longint VMAX = 64'sd2147483647;
  localparam longint VMIN = -64'sd2147483648;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [31:0] i_in;
  logic               i_valid;
  logic               i_ready;
  logic signed [31:0] v_thresh, v_reset;
  logic [3:0]         leak_shift;
  logic [3:0]         refrac_len;
  logic               spike_out, out_valid, pass_done;
  logic [6:0]         spike_idx;
  logic signed [31:0] v_out;
  logic [7:0]         pop_spike_count;
`ifdef LIF_SPIKE_HIST_EN
  logic [31:0]        hist_out;
`endif

  lif_population dut (
    .clk             (clk),
    .reset           (reset),
    .i_in            (i_in),
    .i_valid         (i_valid),
    .i_ready         (i_ready),
    .v_thresh        (v_thresh),
    .v_reset         (v_reset),
    .leak_shift      (leak_shift),
    .refrac_len      (refrac_len),
    .spike_out       (spike_out),
    .spike_idx       (spike_idx),
    .out_valid       (out_valid),
    .v_out           (v_out),
    .pass_done       (pass_done),
`ifdef LIF_SPIKE_HIST_EN
    .hist_out        (hist_out),
`endif
    .pop_spike_count (pop_spike_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // reference model state
  longint      m_v [N];
  int          m_r [N];
  logic [31:0] m_h [N];
  bit          m_fp;
  int          m_idx, m_cnt, m_pop;

  // expected values of the transfer in flight
  bit          e_sp, e_pd;
  longint      e_v;
  logic [31:0] e_hist;

  // last observed result, for directed checks
  logic        o_sp;
  logic [31:0] o_v;
  logic [31:0] o_hist;

  // back-to-back spacing bookkeeping
  bit b2b_mode;
  int last_ov, b2b_viol, b2b_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fp = 1; m_idx = 0; m_cnt = 0; m_pop = 0;
  endtask

  task automatic model_update(input logic signed [31:0] cur);
    longint v, vn, lk;
    int r;
    logic [31:0] h;
    v = m_fp ? longint'(v_reset) : m_v[m_idx];
    r = m_fp ? 0 : m_r[m_idx];
    h = m_fp ? 32'd0 : m_h[m_idx];
    lk = (leak_shift != 0) ? (v >>> leak_shift) : 0;
    vn = v - lk + longint'(cur);
    if (vn > VMAX) vn = VMAX;
    if (vn < VMIN) vn = VMIN;
    e_sp = 0;
    if (r != 0) begin
      m_v[m_idx] = longint'(v_reset);
      m_r[m_idx] = r - 1;
      e_v = longint'(v_reset);
    end else if (vn >= longint'(v_thresh)) begin
      e_sp = 1;
      m_v[m_idx] = longint'(v_reset);
      m_r[m_idx] = int'(refrac_len);
      e_v = vn;
    end else begin
      m_v[m_idx] = vn;
      e_v = vn;
    end
    e_hist = {h[30:0], e_sp};
    m_h[m_idx] = e_hist;
    m_cnt += int'(e_sp);
    e_pd = (m_idx == N - 1);
    if (e_pd) begin
      m_pop = m_cnt;
      m_cnt = 0;
      m_fp  = 0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called at a negedge; returns at the negedge where the result was seen.
  task automatic xfer(input logic signed [31:0] cur, input int gap, input int exp_idx);
    int t;
    repeat (gap) begin
      i_valid = 0;
      i_in    = $urandom;
      @(negedge clk);
    end
    t = 0;
    while (i_ready !== 1'b1 && t < 8) begin @(negedge clk); t++; end
    if (t == 8) check("ready_timeout", 0, 1);
    i_valid = 1;
    i_in    = cur;
    model_update(cur);
    @(posedge clk);
    @(negedge clk);
    check("busy_not_ready", {63'd0, i_ready}, 64'd0);
    // garbage offered while busy must be ignored
    i_in    = $urandom;
    i_valid = 1;
    @(negedge clk);
    i_valid = 0;
    t = 0;
    while (out_valid !== 1'b1 && t < 8) begin @(negedge clk); t++; end
    if (t == 8) check("out_valid_timeout", 0, 1);
    if (b2b_mode) begin
      if (b2b_seen > 0 && (cyc - last_ov) != 2) b2b_viol++;
      b2b_seen++;
      last_ov = cyc;
    end
    check("spike_idx", {57'd0, spike_idx}, 64'(exp_idx));
    check("spike_out", {63'd0, spike_out}, {63'd0, e_sp});
    check("v_out", {32'd0, v_out}, {32'd0, e_v[31:0]});
    check("pass_done", {63'd0, pass_done}, {63'd0, e_pd});
    check("pop_spike_count", {56'd0, pop_spike_count}, 64'(m_pop));
`ifdef LIF_SPIKE_HIST_EN
    check("hist_out", {32'd0, hist_out}, {32'd0, e_hist});
    o_hist = hist_out;
`endif
    o_sp = spike_out;
    o_v  = v_out;
  endtask

  // mode 0: cur on sel_idx only, 1: cur everywhere, 2: random current
  task automatic run_pass(input int mode, input int sel_idx, input logic signed [31:0] cur,
                          input int max_gap);
    logic signed [31:0] c;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: c = (i == sel_idx) ? cur : 32'sd0;
        1: c = cur;
        default: c = $signed(32'($urandom_range(0, 6000))) - 32'sd2000;
      endcase
      xfer(c, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; i_valid = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  int idx5_exp [11] = '{2048, 3840, 5408, 6780, 7981, 9032, 9951, 10756, 0, 0, 2048};
  int pd_seen;

  initial begin
    reset = 1; i_valid = 0; i_in = 0;
    v_thresh = 32'sd10240; v_reset = 0; leak_shift = 0; refrac_len = 0;
    b2b_mode = 0; b2b_viol = 0; b2b_seen = 0; last_ov = 0;
    model_reset();
    #23;
    check("rst_i_ready", {63'd0, i_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_spike_out", {63'd0, spike_out}, 64'd0);
    check("rst_pass_done", {63'd0, pass_done}, 64'd0);
    check("rst_spike_idx", {57'd0, spike_idx}, 64'd0);
    check("rst_v_out", {32'd0, v_out}, 64'd0);
    check("rst_pop", {56'd0, pop_spike_count}, 64'd0);
    @(negedge clk);
    reset = 0;

    // a few results, then reset while an update is in flight
    for (int i = 0; i < 3; i++) xfer(32'sd777, 0, i);
    i_valid = 1; i_in = 32'sd5000;
    @(posedge clk);
    @(negedge clk);
    i_valid = 0;
    check("mid_busy", {63'd0, i_ready}, 64'd0);
    reset = 1;
    #1;
    check("mid_rst_i_ready", {63'd0, i_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_spike_idx", {57'd0, spike_idx}, 64'd0);
    check("mid_rst_v_out", {32'd0, v_out}, 64'd0);
    check("mid_rst_pop", {56'd0, pop_spike_count}, 64'd0);
    @(negedge clk);
    reset = 0;
    model_reset();

    // integration and refractory on index 5
    leak_shift = 3; v_thresh = 32'sd10240; v_reset = 0; refrac_len = 2;
    for (int p = 0; p < 11; p++) begin
      for (int i = 0; i < N; i++) begin
        xfer((i == 5) ? 32'sd2048 : 32'sd0, 0, i);
        if (i == 5) begin
          check($sformatf("idx5_v_pass%0d", p + 1), {32'd0, o_v}, 64'(idx5_exp[p]));
          check($sformatf("idx5_spike_pass%0d", p + 1), {63'd0, o_sp}, {63'd0, (p == 7)});
        end
      end
    end

    // saturation on index 0
    leak_shift = 0; v_thresh = 32'sh7FFFFFFF; v_reset = 0; refrac_len = 0;
    run_pass(0, 0, 32'sh40000000, 0);
    xfer(32'sh40000000, 0, 0);
    check("sat_pos_v", {32'd0, o_v}, 64'h7FFFFFFF);
    check("sat_pos_spike", {63'd0, o_sp}, 64'd1);
    for (int i = 1; i < N; i++) xfer(32'sd0, 0, i);
    for (int p = 0; p < 3; p++) run_pass(0, 0, 32'shC0000000, 0);
    xfer(32'shC0000000, 0, 0);
    check("sat_neg_v", {32'd0, o_v}, 64'h80000000);
    check("sat_neg_spike", {63'd0, o_sp}, 64'd0);
    for (int i = 1; i < N; i++) xfer(32'sd0, 0, i);

    // wrap and population count from a fresh first pass
    do_reset();
    v_thresh = 0; v_reset = -32'sd1; refrac_len = 0; leak_shift = 0;
    pd_seen = 0;
    for (int i = 0; i < N; i++) begin
      xfer(32'sd1, 0, i);
      if (pass_done === 1'b1) pd_seen++;
    end
    check("wrap_pass_done_count", 64'(pd_seen), 64'd1);
    check("wrap_pop_count", {56'd0, pop_spike_count}, 64'd128);
    xfer(32'sd1, 0, 0);
    for (int i = 1; i < N; i++) xfer(32'sd1, 0, i);

    // valid held every cycle: one result per two clocks
    b2b_mode = 1;
    run_pass(1, 0, 32'sd1, 0);
    b2b_mode = 0;
    check("b2b_spacing_violations", 64'(b2b_viol), 64'd0);
    check("b2b_results", 64'(b2b_seen), 64'(N));

    // randomized configuration, current and gaps
    for (int p = 0; p < 3; p++) begin
      leak_shift = 4'($urandom_range(0, 6));
      v_thresh   = $signed(32'($urandom_range(1000, 40000)));
      v_reset    = $signed(32'($urandom_range(0, 400))) - 32'sd200;
      refrac_len = 4'($urandom_range(0, 3));
      run_pass(2, 0, 32'sd0, 5);
    end

`ifdef LIF_SPIKE_HIST_EN
    // spike pattern 1,0,1 on index 3
    do_reset();
    v_reset = 0; v_thresh = 32'sd100; leak_shift = 0; refrac_len = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < N; i++) begin
        xfer((i == 3 && p != 1) ? 32'sd200 : 32'sd0, 0, i);
        if (i == 3 && p == 2) check("hist_pattern_101", {32'd0, o_hist}, 64'h5);
      end
    end
`endif

    i_valid = 0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
